// File: rtl/div32_seq.sv
// Sequential restoring divider for DIV/DIVU: one quotient bit per clock.
// The sign fix-up is applied in a dedicated final cycle, so latency is fixed.
module div32_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q, r_rem, r_dmag, r_dvd_raw;
  logic             r_qneg, r_rneg, r_dz, r_done;
  logic             w_load, w_iter, w_fix;
  logic [WIDTH-1:0] w_dvd_mag, w_dsr_mag;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH+1:0] w_trial;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; a start during the done cycle is still treated as busy
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start && !r_done) w_next = S_RUN;
      S_RUN:   if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_load = 1'b0;
    w_iter = 1'b0;
    w_fix  = 1'b0;
    case (r_state)
      S_IDLE:  w_load = start && !r_done;
      S_RUN:   w_iter = 1'b1;
      S_FIX:   w_fix  = 1'b1;
      default: ;
    endcase
    busy = (r_state != S_IDLE) || r_done;
    done = r_done;
  end

  // Magnitudes: -0x80000000 wraps to 0x80000000, which is the correct unsigned 2^31
  always_comb begin
    w_dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    w_dsr_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    w_sh      = {r_rem, r_q[WIDTH-1]};
    w_trial   = {1'b0, w_sh} - {2'b00, r_dmag};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_dmag      <= '0;
      r_dvd_raw   <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_dz        <= 1'b0;
      r_done      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_load) begin
        r_q       <= w_dvd_mag;
        r_dmag    <= w_dsr_mag;
        r_dvd_raw <= dividend;
        r_rem     <= '0;
        r_cnt     <= '0;
        r_qneg    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        r_rneg    <= is_signed && dividend[WIDTH-1];
        r_dz      <= (divisor == '0);
      end
      if (w_iter) begin
        // A negative trial means the shifted remainder is below the divisor and fits WIDTH bits
        r_q   <= {r_q[WIDTH-2:0], ~w_trial[WIDTH+1]};
        r_rem <= w_trial[WIDTH+1] ? w_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_fix) begin
        if (r_dz) begin
          quotient    <= '1;
          remainder   <= r_dvd_raw;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= r_qneg ? -r_q : r_q;
          remainder   <= r_rneg ? -r_rem : r_rem;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Directed bench for div32_seq: latency, busy window, signed/unsigned results, div-by-zero, reset abort.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int tests = 0;
  int fails = 0;

  div32_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check latency, busy window and results.
  // inj=1 pulses a conflicting start mid-RUN. Returns in the cycle after done.
  task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz, input bit inj);
    int lat = 0;
    int bcnt = 0;
    @(negedge clk);
    is_signed = s; dividend = a; divisor = b; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        start = 1'b0;
        dividend = ~a;
        divisor = b + 32'd3;
      end
      if (inj && k == 5) begin
        start = 1'b1; dividend = 32'd999; divisor = 32'd1; is_signed = ~s;
      end
      if (k == 6) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'd34);
    chk({tag, " busy_cycles"}, 32'(bcnt), 32'd34);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
    @(posedge clk);
    #1;
    chk({tag, " done_pulse_end"}, {30'd0, done, busy}, 32'd0);
    chk({tag, " quotient_hold"}, quotient, eq);
  endtask

  initial begin
    int dcnt;
    #12;
    chk("reset busy/done/dz", {29'd0, busy, done, div_by_zero}, 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("divu_ffffffff_16", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0, 1'b0);

    // Abort an op with reset at E10; no done must appear
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd3; start = 1'b1;
    dcnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) dcnt++;
    end
    rst = 1'b1;
    #2;
    chk("abort reset busy/done/dz", {29'd0, busy, done, div_by_zero}, 32'd0);
    chk("abort reset quotient", quotient, 32'd0);
    chk("abort reset remainder", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    chk("aborted op no done", 32'(dcnt), 32'd0);

    run_op("divu_7_2", 1'b0, 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b0);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    run_op("divu_by_zero", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);
    run_op("divu_10_5", 1'b0, 32'd10, 32'd5, 32'd2, 32'd0, 1'b0, 1'b0);
    run_op("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    run_op("divu_100_7_inj", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    run_op("divu_9_4_b2b", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 1'b0);
    run_op("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
